// File: rtl/sodor_imem_pkg.sv
// Shared types and constants for the Sodor instruction-memory responder.
package sodor_imem_pkg;

  localparam int unsigned WORD_SIZE = 32;

  // RV32I major opcodes
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [WORD_SIZE-1:0] NOP_INSN = {25'd0, OP_IMM};

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} fsm_state_t;

  // One response beat: error flag travels alongside its instruction word
  typedef struct packed {
    logic                 err;
    logic [WORD_SIZE-1:0] data;
  } imem_resp_t;

endpackage

// File: rtl/sodor_imem_resp_fifo.sv
// In-order response FIFO of {err,data} beats with a single-cycle flush.
module sodor_imem_resp_fifo
  import sodor_imem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  imem_resp_t push_entry,
  input  logic       pop,
  output logic       empty,
  output imem_resp_t head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  imem_resp_t    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy tracking; flush empties the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/sodor_imem_responder.sv
// Instruction-memory responder: backdoor-loadable word array, fixed-latency
// read pipeline, in-order response FIFO and kill/flush control.
// Optional feature macro: IMEM_MISALIGN_CHECK_EN (misaligned fetches return NOP with err=1).
module sodor_imem_responder
  import sodor_imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned QDEPTH      = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           io_imem_req_valid,
  output logic                           io_imem_req_ready,
  input  logic [31:0]                    io_imem_req_bits_addr,
  output logic                           io_imem_resp_valid,
  input  logic                           io_imem_resp_ready,
  output logic [31:0]                    io_imem_resp_bits_data,
  input  logic                           io_imem_kill,
  input  logic                           ld_valid,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data
`ifdef IMEM_MISALIGN_CHECK_EN
  ,
  output logic                           io_imem_resp_bits_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned OW = $clog2(QDEPTH + 1);

  logic [WORD_SIZE-1:0] mem [DEPTH_WORDS];
  fsm_state_t           state, state_nxt;
  logic [OW-1:0]        outstanding, outstanding_nxt;
  logic                 accept, fire;
  logic [29:0]          word_idx;
  imem_resp_t           rd_entry;
  logic                 push_v;
  imem_resp_t           push_d;
  logic                 fifo_empty;
  imem_resp_t           fifo_head;

  // Handshakes; ready is forced low while reset is asserted
  assign io_imem_req_ready = !reset && (state != FLUSH) && (outstanding < OW'(QDEPTH));
  assign accept            = io_imem_req_valid && io_imem_req_ready;
  assign fire              = io_imem_resp_valid && io_imem_resp_ready;

  // Backdoor load port, writable in every state
  always_ff @(posedge clk) begin
    if (ld_valid) mem[ld_addr] <= ld_data;
  end

  // Address decode and array read in the accept cycle (sees pre-write contents)
  always_comb begin
    word_idx      = 30'((io_imem_req_bits_addr - BASE_ADDR) >> 2);
    rd_entry.err  = 1'b0;
    rd_entry.data = (word_idx < 30'(DEPTH_WORDS)) ? mem[word_idx[AW-1:0]] : NOP_INSN;
`ifdef IMEM_MISALIGN_CHECK_EN
    if (io_imem_req_bits_addr[1:0] != 2'b00) begin
      rd_entry.err  = 1'b1;
      rd_entry.data = NOP_INSN;
    end
`endif
  end

  // Latency pipeline: LATENCY-1 register stages, the FIFO write is the final stage
  generate
    if (LATENCY > 1) begin : g_pipe
      logic [LATENCY-2:0] v_q;
      imem_resp_t         d_q [LATENCY-1];

      // Valid shift chain, cleared by kill
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_q <= '0;
        end else if (io_imem_kill) begin
          v_q <= '0;
        end else begin
          v_q[0] <= accept;
          for (int unsigned i = 1; i < LATENCY - 1; i++) v_q[i] <= v_q[i-1];
        end
      end

      // Payload shift chain, qualified by v_q
      always_ff @(posedge clk) begin
        d_q[0] <= rd_entry;
        for (int unsigned i = 1; i < LATENCY - 1; i++) d_q[i] <= d_q[i-1];
      end

      assign push_v = v_q[LATENCY-2];
      assign push_d = d_q[LATENCY-2];
    end else begin : g_nopipe
      assign push_v = accept;
      assign push_d = rd_entry;
    end
  endgenerate

  sodor_imem_resp_fifo #(
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (io_imem_kill),
    .push       (push_v),
    .push_entry (push_d),
    .pop        (fire),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  // Response outputs, zero whenever nothing is presented
  always_comb begin
    io_imem_resp_valid     = !fifo_empty && (state != FLUSH);
    io_imem_resp_bits_data = io_imem_resp_valid ? fifo_head.data : '0;
  end

`ifdef IMEM_MISALIGN_CHECK_EN
  assign io_imem_resp_bits_err = io_imem_resp_valid && fifo_head.err;
`else
  logic unused_err;
  assign unused_err = fifo_head.err;
`endif

  // Next-state and outstanding-count logic; kill overrides everything
  always_comb begin
    state_nxt       = state;
    outstanding_nxt = outstanding;
    if (io_imem_kill) begin
      state_nxt       = FLUSH;
      outstanding_nxt = '0;
    end else begin
      outstanding_nxt = outstanding + OW'(accept) - OW'(fire);
      case (state)
        IDLE:    if (accept) state_nxt = BUSY;
        BUSY:    if (outstanding_nxt == '0) state_nxt = IDLE;
        FLUSH:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
    end
  end

endmodule

// File: tb/tb_sodor_imem_responder.sv
// Self-checking bench for sodor_imem_responder against a queue-based reference model.
module tb_sodor_imem_responder;

  localparam int unsigned LAT = 1;
  localparam int unsigned QD  = 2;
  localparam int unsigned DW  = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        kill, ld_valid;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
`ifdef IMEM_MISALIGN_CHECK_EN
  logic        resp_err;
`endif

  sodor_imem_responder #(
    .DEPTH_WORDS(DW), .LATENCY(LAT), .QDEPTH(QD), .BASE_ADDR(32'h0)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .io_imem_req_valid      (req_valid),
    .io_imem_req_ready      (req_ready),
    .io_imem_req_bits_addr  (req_addr),
    .io_imem_resp_valid     (resp_valid),
    .io_imem_resp_ready     (resp_ready),
    .io_imem_resp_bits_data (resp_data),
    .io_imem_kill           (kill),
    .ld_valid               (ld_valid),
    .ld_addr                (ld_addr),
    .ld_data                (ld_data)
`ifdef IMEM_MISALIGN_CHECK_EN
    ,
    .io_imem_resp_bits_err  (resp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory image, queue of outstanding fetches, flush flag
  typedef struct { int vis; logic [31:0] data; logic err; } exp_t;
  exp_t        q[$];
  logic [31:0] mm [DW];
  int          cyc;
  bit          in_flush;
  int          n_pass, n_total;

  function automatic exp_t lookup(input logic [31:0] a);
    exp_t        e;
    logic [31:0] idx;
    idx    = a / 32'd4;
    e.vis  = 0;
    e.err  = 1'b0;
    e.data = (idx < DW) ? mm[idx[7:0]] : NOP;
`ifdef IMEM_MISALIGN_CHECK_EN
    if (a % 32'd4 != 0) begin
      e.data = NOP;
      e.err  = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic drive(input logic rv, input logic [31:0] a, input logic rr, input logic k);
    req_valid = rv; req_addr = a; resp_ready = rr; kill = k; ld_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
  endtask

  task automatic model_exp(output logic er, output logic ev, output exp_t h);
    er = !in_flush && (q.size() < QD);
    ev = !in_flush && (q.size() > 0) && (q[0].vis <= cyc);
    h.vis = 0; h.data = '0; h.err = 1'b0;
    if (ev) h = q[0];
  endtask

  // Apply this cycle's stimulus to the model, then move to the next falling edge
  task automatic advance();
    logic er, ev;
    exp_t h, e;
    model_exp(er, ev, h);
    if (kill) begin
      q.delete();
      in_flush = 1'b1;
    end else begin
      in_flush = 1'b0;
      if (ev && resp_ready) void'(q.pop_front());
      if (req_valid && er) begin
        e = lookup(req_addr);
        e.vis = cyc + LAT;
        q.push_back(e);
      end
    end
    if (ld_valid) mm[ld_addr] = ld_data;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; drive(0, 0, 0, 0); ld_addr = '0; ld_data = '0;
    q.delete(); in_flush = 1'b0; cyc = 0;
    @(negedge clk); #1;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL reset req_ready: got %b want 0", req_ready); else n_pass++;
    n_total++; if (resp_data !== 32'h0) $display("FAIL reset resp_data: got %h want 0", resp_data); else n_pass++;
`ifdef IMEM_MISALIGN_CHECK_EN
    n_total++; if (resp_err !== 1'b0) $display("FAIL reset resp_err: got %b want 0", resp_err); else n_pass++;
`endif
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      drive(0, 0, 0, 0); load(8'(i), $urandom); #1; advance();
    end
  endtask

  task automatic test_single();
    logic rv [3] = '{1, 0, 0};
    logic er, ev; exp_t h;
    drive(0, 0, 1, 0); load(8'd0, 32'h0050_0093); #1; advance();
    for (int k = 0; k < 3; k++) begin
      drive(rv[k], 32'h0, 1, 0); #1; model_exp(er, ev, h);
      n_total++; if (req_ready !== er) $display("FAIL single[%0d] req_ready: got %b want %b", k, req_ready, er); else n_pass++;
      n_total++; if (resp_valid !== ev) $display("FAIL single[%0d] resp_valid: got %b want %b", k, resp_valid, ev); else n_pass++;
      if (k == 1) begin
        n_total++; if (resp_data !== 32'h0050_0093) $display("FAIL single data: got %h want 00500093", resp_data); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3] = '{32'h0050_0093, 32'h00a0_0113, 32'h00f0_0193};
    logic er, ev; exp_t h;
    drive(0, 0, 1, 0); load(8'd1, w[1]); #1; advance();
    drive(0, 0, 1, 0); load(8'd2, w[2]); #1; advance();
    for (int k = 0; k < 5; k++) begin
      drive(k < 3, 32'(k * 4), 1, 0); #1; model_exp(er, ev, h);
      if (k < 3) begin
        n_total++; if (req_ready !== 1'b1) $display("FAIL b2b[%0d] req_ready: got %b want 1", k, req_ready); else n_pass++;
      end
      n_total++; if (resp_valid !== ev) $display("FAIL b2b[%0d] resp_valid: got %b want %b", k, resp_valid, ev); else n_pass++;
      if (k >= 1 && k <= 3) begin
        n_total++; if (resp_data !== w[k-1]) $display("FAIL b2b[%0d] data: got %h want %h", k, resp_data, w[k-1]); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic rv [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic rr [7] = '{0, 0, 0, 0, 1, 1, 1};
    logic er, ev; exp_t h;
    for (int k = 0; k < 7; k++) begin
      drive(rv[k], 32'(k * 4), rr[k], 0); #1; model_exp(er, ev, h);
      n_total++; if (req_ready !== er) $display("FAIL bp[%0d] req_ready: got %b want %b", k, req_ready, er); else n_pass++;
      n_total++; if (resp_valid !== ev) $display("FAIL bp[%0d] resp_valid: got %b want %b", k, resp_valid, ev); else n_pass++;
      if (ev) begin
        n_total++; if (resp_data !== h.data) $display("FAIL bp[%0d] data: got %h want %h", k, resp_data, h.data); else n_pass++;
      end
      if (k == 3) begin
        n_total++; if (resp_data !== mm[0]) $display("FAIL bp held data: got %h want %h", resp_data, mm[0]); else n_pass++;
      end
      if (k == 6) begin
        n_total++; if (req_ready !== 1'b1) $display("FAIL bp drained req_ready: got %b want 1", req_ready); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_kill();
    logic        rv [8] = '{1, 1, 0, 0, 0, 1, 0, 0};
    logic [31:0] ad [8] = '{0, 4, 0, 0, 0, 4, 0, 0};
    logic        rr [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    logic        kl [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    logic er, ev; exp_t h;
    for (int k = 0; k < 8; k++) begin
      drive(rv[k], ad[k], rr[k], kl[k]); #1; model_exp(er, ev, h);
      n_total++; if (req_ready !== er) $display("FAIL kill[%0d] req_ready: got %b want %b", k, req_ready, er); else n_pass++;
      n_total++; if (resp_valid !== ev) $display("FAIL kill[%0d] resp_valid: got %b want %b", k, resp_valid, ev); else n_pass++;
      if (ev) begin
        n_total++; if (resp_data !== h.data) $display("FAIL kill[%0d] data: got %h want %h", k, resp_data, h.data); else n_pass++;
      end
      if (k == 3) begin
        n_total++; if ({resp_valid, req_ready} !== 2'b00) $display("FAIL kill flush: got v=%b r=%b want 0 0", resp_valid, req_ready); else n_pass++;
      end
      if (k == 6) begin
        n_total++; if (resp_data !== mm[1]) $display("FAIL kill refetch data: got %h want %h", resp_data, mm[1]); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_boundary();
    logic [31:0] ad [4] = '{32'h400, 32'h3FC, 32'h2, 32'hFFFF_FFFC};
    logic er, ev; exp_t h;
    for (int k = 0; k < 8; k++) begin
      drive(k % 2 == 0, ad[k / 2], 1, 0); #1; model_exp(er, ev, h);
      n_total++; if (resp_valid !== ev) $display("FAIL bound[%0d] resp_valid: got %b want %b", k, resp_valid, ev); else n_pass++;
      if (ev) begin
        n_total++; if (resp_data !== h.data) $display("FAIL bound[%0d] data: got %h want %h", k, resp_data, h.data); else n_pass++;
`ifdef IMEM_MISALIGN_CHECK_EN
        n_total++; if (resp_err !== h.err) $display("FAIL bound[%0d] err: got %b want %b", k, resp_err, h.err); else n_pass++;
`endif
      end
      if (k == 1) begin
        n_total++; if (resp_data !== NOP) $display("FAIL bound oob data: got %h want %h", resp_data, NOP); else n_pass++;
      end
      if (k == 5) begin
`ifdef IMEM_MISALIGN_CHECK_EN
        n_total++; if ({resp_err, resp_data} !== {1'b1, NOP}) $display("FAIL bound misalign: got err=%b %h want 1 %h", resp_err, resp_data, NOP); else n_pass++;
`else
        n_total++; if (resp_data !== mm[0]) $display("FAIL bound misalign: got %h want %h", resp_data, mm[0]); else n_pass++;
`endif
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    logic er, ev; exp_t h;
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'(k * 4 + 16), 0, 0); #1; advance();
    end
    drive(0, 0, 0, 0); #1;
    reset = 1'b1; #1;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL rstmid resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL rstmid req_ready: got %b want 0", req_ready); else n_pass++;
    q.delete(); in_flush = 1'b0;
    @(negedge clk); cyc++; reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(k < 2, 32'(k * 4), 1, 0); #1; model_exp(er, ev, h);
      n_total++; if (req_ready !== er) $display("FAIL rstmid[%0d] req_ready: got %b want %b", k, req_ready, er); else n_pass++;
      n_total++; if (resp_valid !== ev) $display("FAIL rstmid[%0d] resp_valid: got %b want %b", k, resp_valid, ev); else n_pass++;
      if (ev) begin
        n_total++; if (resp_data !== mm[k-1]) $display("FAIL rstmid[%0d] array data: got %h want %h", k, resp_data, mm[k-1]); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic er, ev; exp_t h;
    logic [31:0] a;
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
        2:       a = 32'h400 + 32'($urandom_range(0, 63)) * 32'd4;
        default: a = 32'($urandom_range(0, 255)) * 32'd4;
      endcase
      drive($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) < 3) load(8'($urandom_range(0, 255)), $urandom);
      #1; model_exp(er, ev, h);
      n_total++; if (req_ready !== er) $display("FAIL rand[%0d] req_ready: got %b want %b", k, req_ready, er); else n_pass++;
      n_total++; if (resp_valid !== ev) $display("FAIL rand[%0d] resp_valid: got %b want %b", k, resp_valid, ev); else n_pass++;
      if (ev) begin
        n_total++; if (resp_data !== h.data) $display("FAIL rand[%0d] data: got %h want %h", k, resp_data, h.data); else n_pass++;
`ifdef IMEM_MISALIGN_CHECK_EN
        n_total++; if (resp_err !== h.err) $display("FAIL rand[%0d] err: got %b want %b", k, resp_err, h.err); else n_pass++;
`endif
      end
      advance();
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_kill();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
